// File: rtl/trap_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | trap_pkg : encodings, CSR addresses, cause codes and enums for trap logic |
// | rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
package trap_pkg;

  localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
  localparam logic [31:0] INST_UNIMP  = 32'hc000_1073;
  localparam logic [31:0] INST_MRET   = 32'h3020_0073;
  localparam logic [31:0] INST_SRET   = 32'h1020_0073;

  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_SSTATUS = 12'h100;

  localparam logic [3:0] CAUSE_ILLEGAL    = 4'd2;
  localparam logic [3:0] CAUSE_BREAKPOINT = 4'd3;
  localparam logic [3:0] CAUSE_ECALL_M    = 4'd11;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;
  localparam int SSTATUS_SIE    = 1;
  localparam int SSTATUS_SPIE   = 5;
  localparam int SSTATUS_SPP    = 8;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_W_EPC    = 3'd1,
    ST_W_CAUSE  = 3'd2,
    ST_W_STATUS = 3'd3,
    ST_REDIR    = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    KIND_TRAP = 2'd0,
    KIND_MRET = 2'd1,
    KIND_SRET = 2'd2
  } kind_t;

endpackage
`default_nettype wire

// File: rtl/trap_sequencer_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | trap_sequencer_if : valid/ready CSR write port                           |
// | rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
interface trap_sequencer_if #(
  parameter int XLEN = 64
);
  logic            csr_wr_valid;
  logic [11:0]     csr_wr_addr;
  logic [XLEN-1:0] csr_wr_data;
  logic            csr_wr_ready;

  modport master (output csr_wr_valid, csr_wr_addr, csr_wr_data, input csr_wr_ready);
  modport slave  (input csr_wr_valid, csr_wr_addr, csr_wr_data, output csr_wr_ready);
endinterface
`default_nettype wire

// File: rtl/trap_decode.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | trap_decode : exact-match decode of trap/xret instructions (TRAP_SRET_EN) |
// | rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module trap_decode
  import trap_pkg::*;
(
  input  wire [31:0] inst,
  output logic       hit,
  output kind_t      kind,
  output logic [3:0] cause
);

  always_comb begin
    hit   = 1'b1;
    kind  = KIND_TRAP;
    cause = 4'd0;
    case (inst)
      INST_ECALL:  cause = CAUSE_ECALL_M;
      INST_EBREAK: cause = CAUSE_BREAKPOINT;
      INST_UNIMP:  cause = CAUSE_ILLEGAL;
      INST_MRET:   kind  = KIND_MRET;
`ifdef TRAP_SRET_EN
      INST_SRET:   kind  = KIND_SRET;
`else
      INST_SRET:   cause = CAUSE_ILLEGAL;
`endif
      default:     hit   = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/trap_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | trap_sequencer : trap/xret CSR write sequencer with PC redirect + flush   |
// | optional sret support via TRAP_SRET_EN ; rev 1.0                          |
// +--------------------------------------------------------------------------+
module trap_sequencer
  import trap_pkg::*;
#(
  parameter int              XLEN       = 64,
  parameter logic [XLEN-1:0] MTVEC_MASK = 64'h3
) (
  input  wire                 clk,
  input  wire                 rst,
  input  wire                 ex_valid,
  input  wire  [31:0]         ex_inst,
  input  wire  [XLEN-1:0]     ex_pc,
  input  wire  [XLEN-1:0]     mtvec_data,
  input  wire  [XLEN-1:0]     mepc_data,
  input  wire  [XLEN-1:0]     mstatus_data,
  input  wire  [XLEN-1:0]     sepc_data,
  input  wire  [XLEN-1:0]     sstatus_data,
  trap_sequencer_if.master    csr,
  output logic                stall,
  output logic                flush,
  output logic                redirect_valid,
  output logic [XLEN-1:0]     redirect_pc
);

  state_t          state;
  logic            dec_hit;
  kind_t           dec_kind;
  logic [3:0]      dec_cause;
  logic            detect;
  logic [XLEN-1:0] status_new;
  logic [11:0]     status_addr;
  logic [XLEN-1:0] target_new;

  logic [3:0]      cause_q;
  logic [XLEN-1:0] status_q;
  logic [XLEN-1:0] target_q;
  logic            wr_valid_q;
  logic [11:0]     wr_addr_q;
  logic [XLEN-1:0] wr_data_q;

  trap_decode u_decode (
    .inst  (ex_inst),
    .hit   (dec_hit),
    .kind  (dec_kind),
    .cause (dec_cause)
  );

  // rst gates detect so stall reads 0 throughout reset
  assign detect = rst && (state == ST_IDLE) && ex_valid && dec_hit;
  assign stall  = detect || (state != ST_IDLE);

  always_comb begin
    status_new  = mstatus_data;
    status_addr = CSR_MSTATUS;
    target_new  = mtvec_data & ~MTVEC_MASK;
    case (dec_kind)
      KIND_MRET: begin
        status_new[MSTATUS_MIE]                   = mstatus_data[MSTATUS_MPIE];
        status_new[MSTATUS_MPIE]                  = 1'b1;
        status_new[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b00;
        target_new                                = mepc_data;
      end
`ifdef TRAP_SRET_EN
      KIND_SRET: begin
        status_new               = sstatus_data;
        status_new[SSTATUS_SIE]  = sstatus_data[SSTATUS_SPIE];
        status_new[SSTATUS_SPIE] = 1'b1;
        status_new[SSTATUS_SPP]  = 1'b0;
        status_addr              = CSR_SSTATUS;
        target_new               = sepc_data;
      end
`endif
      default: begin
        status_new[MSTATUS_MPIE]                  = mstatus_data[MSTATUS_MIE];
        status_new[MSTATUS_MIE]                   = 1'b0;
        status_new[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
      end
    endcase
  end

`ifndef TRAP_SRET_EN
  logic unused_sret;
  assign unused_sret = ^{sepc_data, sstatus_data};
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= ST_IDLE;
      cause_q        <= '0;
      status_q       <= '0;
      target_q       <= '0;
      wr_valid_q     <= 1'b0;
      wr_addr_q      <= '0;
      wr_data_q      <= '0;
      flush          <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (detect) begin
            cause_q    <= dec_cause;
            status_q   <= status_new;
            target_q   <= target_new;
            wr_valid_q <= 1'b1;
            if (dec_kind == KIND_TRAP) begin
              state     <= ST_W_EPC;
              wr_addr_q <= CSR_MEPC;
              wr_data_q <= ex_pc;
            end else begin
              state     <= ST_W_STATUS;
              wr_addr_q <= status_addr;
              wr_data_q <= status_new;
            end
          end
        end
        ST_W_EPC: begin
          if (csr.csr_wr_ready) begin
            state     <= ST_W_CAUSE;
            wr_addr_q <= CSR_MCAUSE;
            wr_data_q <= {{(XLEN-4){1'b0}}, cause_q};
          end
        end
        ST_W_CAUSE: begin
          if (csr.csr_wr_ready) begin
            state     <= ST_W_STATUS;
            wr_addr_q <= CSR_MSTATUS;
            wr_data_q <= status_q;
          end
        end
        ST_W_STATUS: begin
          if (csr.csr_wr_ready) begin
            state          <= ST_REDIR;
            wr_valid_q     <= 1'b0;
            wr_addr_q      <= '0;
            wr_data_q      <= '0;
            flush          <= 1'b1;
            redirect_valid <= 1'b1;
            redirect_pc    <= target_q;
          end
        end
        ST_REDIR: begin
          state          <= ST_IDLE;
          flush          <= 1'b0;
          redirect_valid <= 1'b0;
          redirect_pc    <= '0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign csr.csr_wr_valid = wr_valid_q;
  assign csr.csr_wr_addr  = wr_addr_q;
  assign csr.csr_wr_data  = wr_data_q;

endmodule
`default_nettype wire
